mem_resp_slave: RTL and testbench
=================================

Name: mem_resp_slave

Overview:
Bus target that answers the core's memory request/response handshake from the data-memory side.
- Accepts one request per handshake: address, write data, byte select and write enable.
- Performs byte-masked writes into a local word-organised RAM array, or returns read words.
- Responses are delivered through a valid/ready channel after a configurable number of wait states.
- Sits behind the core's load/store unit as the data RAM, or behind the bus fabric as a RAM slave.

Parameters:
- ADDR_WIDTH, 12: word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits.
- BASE_ADDR, 32'h1000_0000: byte base address of the window; must be aligned to 4*2**ADDR_WIDTH.
- WAIT_CYCLES, 0: extra cycles inserted between request accept and response valid; range 0..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request can be accepted this cycle
- addr_i  in  32  byte address
- data_i  in  32  write data, already lane-aligned by the initiator
- sel_i  in  4  byte-lane enables; bit n covers data bits 8n+7:8n
- we_i  in  1  1 = write, 0 = read
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  initiator accepts response
- data_o  out  32  read data; full word, lane extraction is done by the initiator
- err_o  out  1  response error flag, valid with rsp_valid_o

Behaviour:
- Handshakes:
  - Request accepted on req_valid_i & req_ready_o.
  - Response consumed on rsp_valid_o & rsp_ready_i.
- FSM states IDLE, WAIT, RESP. Reset state is IDLE.
- Reset values: rsp_valid_o=0, data_o=0, err_o=0, wait counter=0. RAM contents are not reset.
- IDLE:
  - req_ready_o=1.
  - On accept: go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else go to RESP.
- WAIT:
  - req_ready_o=0; counter decrements each cycle.
  - When counter==0, go to RESP the next cycle.
- RESP:
  - rsp_valid_o=1; data_o and err_o are held stable until the response handshake.
  - On handshake with no new accept: go to IDLE.
  - req_ready_o = rsp_ready_i when WAIT_CYCLES==0, else 0. This allows back-to-back accept in the response-handshake cycle.
  - A back-to-back accept restarts the RESP (or WAIT) path for the new request.
- Accept-cycle actions (the RAM is acted on only at accept):
  - Word index = addr_i[ADDR_WIDTH+1:2]; addr_i[1:0] is ignored.
  - Write: each lane with sel_i[n]=1 is updated from data_i; other lanes are unchanged. The response data register is loaded with 0.
  - Read: the response data register is loaded with the current RAM word, using read-before-write ordering relative to the same cycle (irrelevant, since only one access is made per cycle).
  - A write with sel_i=0 is a legal no-op and still gets a response.
- Latency: read data appears on data_o with rsp_valid_o exactly 1+WAIT_CYCLES cycles after the accept edge.
- Ordering and throughput:
  - Back-to-back write then read to the same word: the read returns the new data.
  - Throughput with WAIT_CYCLES=0 and rsp_ready_i held high: 1 transaction per cycle.
- Counter wrap: not possible, because it is only loaded in IDLE/RESP and stops at 0.
- Reset asserted mid-transaction:
  - The pending response is discarded and the FSM returns to IDLE.
  - A write already performed at accept stays in RAM.

Optional Feature:
MEM_RESP_SLAVE_RANGE_CHK_EN
- Defined:
  - At accept, address checks are applied: out-of-window (addr_i - BASE_ADDR >= 4*2**ADDR_WIDTH) and misaligned (addr_i[1:0]!=0 with sel_i==4'hF).
  - On a failing request: the RAM is not written, data_o=0 and err_o=1 in the response. Timing is identical to a normal response.
- Undefined:
  - No checks; upper address bits are ignored, so accesses alias modulo the RAM size.
  - err_o is tied to 0.

Decomposition:
- Shared package/include (defines):
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Bus width constants (32-bit data, 4-bit select).
  - Error code constant.
- Sub-module: mem_resp_ram.
  - Byte-enable synchronous RAM: clk, en, we, sel[3:0], addr, wdata, rdata.
  - Registered read output.
  - Keeps the FSM/handshake logic separate from the storage array so it can be swapped for a technology macro.

Test Plan:
- Write then read back (WAIT_CYCLES=0): write addr 0x1000_0010, data 0xDEAD_BEEF, sel 4'hF; then read the same address -> rsp_valid_o 1 cycle after each accept; read data_o=0xDEAD_BEEF, err_o=0.
- Byte-masked write: preset word 0x1122_3344; write 0xAA00_0000 with sel 4'b1000 -> read returns 0xAA22_3344.
- Response backpressure: read accepted, rsp_ready_i held 0 for 5 cycles -> rsp_valid_o stays 1, data_o stable, req_ready_o=0; completes on the cycle rsp_ready_i=1.
- Wait states (WAIT_CYCLES=3): read accept at cycle t -> rsp_valid_o first high at t+4; req_ready_o low from t+1 until return to IDLE.
- Back-to-back streaming (WAIT_CYCLES=0): req_valid_i and rsp_ready_i held high for 8 sequential reads -> one response per cycle, in order, with no bubbles.
- Range check (MEM_RESP_SLAVE_RANGE_CHK_EN defined): write to 0x2000_0000 -> err_o=1, data_o=0, RAM unchanged. Mid-transaction reset: pulse rst_n low during WAIT -> rsp_valid_o=0 and the FSM is in IDLE after release.

Source files
------------

// File: rtl/mem_resp_slave_pkg.sv
// Shared types and constants for the mem_resp_slave data-RAM target.
package mem_resp_slave_pkg;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic ERR_NONE = 1'b0;
   localparam logic ERR_ADDR = 1'b1;
endpackage

// File: rtl/mem_resp_ram.sv
// Word-organised byte-enable synchronous RAM with registered read-before-write output.
import mem_resp_slave_pkg::*;

module mem_resp_ram #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [SEL_W-1:0]      sel,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         if (we) begin
            for (int n = 0; n < SEL_W; n++) begin
               if (sel[n]) mem[addr][8*n +: 8] <= wdata[8*n +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/mem_resp_slave.sv
// Request/response RAM target with configurable wait states.
// Optional address checking enabled by defining MEM_RESP_SLAVE_RANGE_CHK_EN.
import mem_resp_slave_pkg::*;

module mem_resp_slave #(
   parameter int          ADDR_WIDTH  = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [31:0]       addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [SEL_W-1:0]  sel_i,
   input  logic              we_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic              err_o
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              rd_ok_q;
   logic              accept;
   logic              rsp_done;
   logic              bad;
   logic [DATA_W-1:0] ram_rdata;

   // Ready in RESP only without wait states, so a new request can ride the handshake cycle.
   assign req_ready_o = (state_q == IDLE) ||
                        ((state_q == RESP) && (WAIT_CYCLES == 0) && rsp_ready_i);
   assign accept      = req_valid_i & req_ready_o;
   assign rsp_done    = rsp_valid_o & rsp_ready_i;

`ifdef MEM_RESP_SLAVE_RANGE_CHK_EN
   logic [31:0] offset;
   logic        err_q;
   assign offset = addr_i - BASE_ADDR;
   assign bad    = (offset[31:ADDR_WIDTH+2] != '0) ||
                   ((addr_i[1:0] != 2'b00) && (sel_i == 4'hF));
   assign err_o  = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      err_q <= ERR_NONE;
      else if (accept) err_q <= bad ? ERR_ADDR : ERR_NONE;
   end
`else
   logic unused_addr;
   assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};
   assign bad         = 1'b0;
   assign err_o       = ERR_NONE;
`endif

   mem_resp_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .en    (accept),
      .we    (we_i & ~bad),
      .sel   (sel_i),
      .addr  (addr_i[ADDR_WIDTH+1:2]),
      .wdata (data_i),
      .rdata (ram_rdata)
   );

   // RAM output only changes on accept, so it stays stable for the whole RESP phase.
   assign data_o = rd_ok_q ? ram_rdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         rsp_valid_o <= 1'b0;
         rd_ok_q     <= 1'b0;
      end else if (accept) begin
         rd_ok_q <= ~we_i & ~bad;
         if (WAIT_CYCLES > 0) begin
            state_q     <= WAIT;
            cnt_q       <= WAIT_LOAD;
            rsp_valid_o <= 1'b0;
         end else begin
            state_q     <= RESP;
            rsp_valid_o <= 1'b1;
         end
      end else begin
         case (state_q)
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= RESP;
                  rsp_valid_o <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (rsp_done) begin
                  state_q     <= IDLE;
                  rsp_valid_o <= 1'b0;
               end
            end
            IDLE:    ;
            default: begin
               state_q     <= IDLE;
               rsp_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_resp_slave.sv
// Bench for mem_resp_slave: zero-wait and three-wait-state instances, table vectors plus random model check.
module tb_mem_resp_slave;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] addr, wdata;
   logic [3:0]  sel;
   logic        we;
   logic        rv0 = 1'b0, rr0 = 1'b1, rdy0, vld0, err0;
   logic        rv3 = 1'b0, rr3 = 1'b1, rdy3, vld3, err3;
   logic [31:0] rd0, rd3;

   mem_resp_slave #(.ADDR_WIDTH(12), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid_i(rv0), .req_ready_o(rdy0), .addr_i(addr),
      .data_i(wdata), .sel_i(sel), .we_i(we), .rsp_valid_o(vld0), .rsp_ready_i(rr0),
      .data_o(rd0), .err_o(err0));

   mem_resp_slave #(.ADDR_WIDTH(12), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid_i(rv3), .req_ready_o(rdy3), .addr_i(addr),
      .data_i(wdata), .sel_i(sel), .we_i(we), .rsp_valid_o(vld3), .rsp_ready_i(rr3),
      .data_o(rd3), .err_o(err3));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: plain word array indexed by the aliased word address.
   logic [31:0] mdl [4096];

   function automatic logic exp_err(input logic [31:0] a, input logic [3:0] s);
`ifdef MEM_RESP_SLAVE_RANGE_CHK_EN
      return ((a - BASE) >= 32'h4000) || ((a[1:0] != 2'b00) && (s == 4'hF));
`else
      return (a === 32'hx) && (s === 4'hx);
`endif
   endfunction

   task automatic model_txn(input bit w, input logic [31:0] a, d, input logic [3:0] s,
                            output logic [31:0] ed, output logic ee);
      int idx;
      idx = int'(a[13:2]);
      ee  = exp_err(a, s);
      ed  = 32'h0;
      if (!ee) begin
         if (w) begin
            for (int n = 0; n < 4; n++)
               if (s[n]) mdl[idx][8*n +: 8] = d[8*n +: 8];
         end else begin
            ed = mdl[idx];
         end
      end
   endtask

   task automatic txn0(input bit w, input logic [31:0] a, d, input logic [3:0] s, input int stall,
                       input logic [31:0] ed, input logic ee, input string nm);
      int lat;
      logic [31:0] held;
      we = w; addr = a; wdata = d; sel = s; rv0 = 1'b1; rr0 = (stall == 0);
      chk({nm, "/req_ready"}, {31'b0, rdy0}, 32'd1);
      @(posedge clk); #1;
      rv0 = 1'b0;
      lat = 1;
      while (!vld0 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "/latency"}, 32'(lat), 32'd1);
      chk({nm, "/data"}, rd0, ed);
      chk({nm, "/err"}, {31'b0, err0}, {31'b0, ee});
      held = rd0;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         chk({nm, "/hold_valid"}, {31'b0, vld0}, 32'd1);
         chk({nm, "/hold_data"}, rd0, held);
         chk({nm, "/hold_ready"}, {31'b0, rdy0}, 32'd0);
      end
      rr0 = 1'b1;
      @(posedge clk); #1;
      chk({nm, "/done"}, {31'b0, vld0}, 32'd0);
   endtask

   task automatic txn3(input bit w, input logic [31:0] a, d, ed, input string nm);
      we = w; addr = a; wdata = d; sel = 4'hF; rv3 = 1'b1; rr3 = 1'b1;
      chk({nm, "/req_ready"}, {31'b0, rdy3}, 32'd1);
      @(posedge clk); #1;
      rv3 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk({nm, "/wait_valid"}, {31'b0, vld3}, 32'd0);
         chk({nm, "/wait_ready"}, {31'b0, rdy3}, 32'd0);
         @(posedge clk); #1;
      end
      chk({nm, "/valid"}, {31'b0, vld3}, 32'd1);
      chk({nm, "/resp_ready"}, {31'b0, rdy3}, 32'd0);
      chk({nm, "/data"}, rd3, ed);
      chk({nm, "/err"}, {31'b0, err3}, 32'd0);
      @(posedge clk); #1;
      chk({nm, "/done"}, {31'b0, vld3}, 32'd0);
      chk({nm, "/idle_ready"}, {31'b0, rdy3}, 32'd1);
   endtask

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int          stall;
      logic [31:0] ed;
      logic        ee;
   } vec_t;

   vec_t tbl[11];

   initial begin
      logic [31:0] ed, a, d, hi;
      logic        ee;
      logic [31:0] strm [8];
      logic [3:0]  s;
      bit          w;

      tbl[0]  = '{1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0};
      tbl[1]  = '{1'b0, 32'h1000_0010, 32'h0,         4'hF, 0, 32'hDEAD_BEEF, 1'b0};
      tbl[2]  = '{1'b1, 32'h1000_0020, 32'h1122_3344, 4'hF, 0, 32'h0, 1'b0};
      tbl[3]  = '{1'b1, 32'h1000_0020, 32'hAA00_0000, 4'h8, 1, 32'h0, 1'b0};
      tbl[4]  = '{1'b0, 32'h1000_0020, 32'h0,         4'hF, 2, 32'hAA22_3344, 1'b0};
      tbl[5]  = '{1'b1, 32'h1000_0020, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 1'b0};
      tbl[6]  = '{1'b0, 32'h1000_0020, 32'h0,         4'hF, 0, 32'hAA22_3344, 1'b0};
      tbl[7]  = '{1'b1, 32'h1000_0020, 32'h00BB_00CC, 4'h5, 0, 32'h0, 1'b0};
      tbl[8]  = '{1'b0, 32'h1000_0023, 32'h0,         4'h0, 0, 32'hAABB_33CC, 1'b0};
`ifdef MEM_RESP_SLAVE_RANGE_CHK_EN
      tbl[9]  = '{1'b0, 32'h2000_0012, 32'h0,         4'h0, 0, 32'h0, 1'b1};
`else
      tbl[9]  = '{1'b0, 32'h2000_0012, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0};
`endif
      tbl[10] = '{1'b0, 32'h1000_0010, 32'h0,         4'hF, 5, 32'hDEAD_BEEF, 1'b0};

      we = 1'b0; addr = 32'h0; wdata = 32'h0; sel = 4'h0;
      #2;
      chk("rst/valid0", {31'b0, vld0}, 32'd0);
      chk("rst/data0", rd0, 32'd0);
      chk("rst/err0", {31'b0, err0}, 32'd0);
      chk("rst/valid3", {31'b0, vld3}, 32'd0);
      chk("rst/data3", rd3, 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst/ready0", {31'b0, rdy0}, 32'd1);

      for (int i = 0; i < 11; i++)
         txn0(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].stall, tbl[i].ed, tbl[i].ee,
              $sformatf("vec%0d", i));

`ifdef MEM_RESP_SLAVE_RANGE_CHK_EN
      txn0(1'b1, 32'h2000_0000, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b1, "oor_write");
      txn0(1'b1, 32'h1000_0011, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b1, "misalign_write");
      txn0(1'b0, 32'h1000_0010, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, "ram_unchanged");
`endif

      // Write then read of the same word on consecutive cycles, then 8 streamed reads.
      for (int i = 0; i < 8; i++) begin
         strm[i] = $urandom;
         txn0(1'b1, BASE + 32'h200 + 32'(4 * i), strm[i], 4'hF, 0, 32'h0, 1'b0, "strm_fill");
      end
      rv0 = 1'b1; rr0 = 1'b1;
      we = 1'b1; addr = BASE + 32'h300; wdata = 32'h600D_CAFE; sel = 4'hF;
      @(posedge clk); #1;
      chk("b2b/wr_valid", {31'b0, vld0}, 32'd1);
      we = 1'b0; sel = 4'h0;
      chk("b2b/ready", {31'b0, rdy0}, 32'd1);
      @(posedge clk); #1;
      chk("b2b/rd_valid", {31'b0, vld0}, 32'd1);
      chk("b2b/rd_data", rd0, 32'h600D_CAFE);
      for (int i = 0; i < 8; i++) begin
         addr = BASE + 32'h200 + 32'(4 * i);
         chk("strm/ready", {31'b0, rdy0}, 32'd1);
         @(posedge clk); #1;
         chk("strm/valid", {31'b0, vld0}, 32'd1);
         chk($sformatf("strm/data%0d", i), rd0, strm[i]);
      end
      rv0 = 1'b0;
      @(posedge clk); #1;
      chk("strm/drain", {31'b0, vld0}, 32'd0);

      // Random traffic against the reference model, including aliased and unaligned addresses.
      for (int i = 0; i < 16; i++) begin
         a = BASE + 32'((64 + i) * 4);
         d = $urandom;
         model_txn(1'b1, a, d, 4'hF, ed, ee);
         txn0(1'b1, a, d, 4'hF, 0, ed, ee, "rnd_init");
      end
      for (int i = 0; i < 150; i++) begin
         hi = ($urandom_range(0, 3) == 0) ? 32'h3000_0000 : BASE;
         a  = hi + 32'((64 + $urandom_range(0, 15)) * 4) + 32'($urandom_range(0, 3));
         d  = $urandom;
         w  = 1'($urandom_range(0, 1));
         s  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         model_txn(w, a, d, s, ed, ee);
         txn0(w, a, d, s, $urandom_range(0, 2), ed, ee, $sformatf("rnd%0d", i));
      end

      // Wait-state instance.
      txn3(1'b1, 32'h1000_0040, 32'h5A5A_1234, 32'h0, "w3_write");
      txn3(1'b0, 32'h1000_0040, 32'h0, 32'h5A5A_1234, "w3_read");

      // Reset during WAIT: response dropped, the write itself survives.
      we = 1'b1; addr = 32'h1000_0044; wdata = 32'h0BAD_F00D; sel = 4'hF; rv3 = 1'b1;
      @(posedge clk); #1;
      rv3 = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("midrst/valid", {31'b0, vld3}, 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("midrst/no_resp", {31'b0, vld3}, 32'd0);
      end
      chk("midrst/idle_ready", {31'b0, rdy3}, 32'd1);
      txn3(1'b0, 32'h1000_0044, 32'h0, 32'h0BAD_F00D, "midrst_read");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
